// File: rtl/fcn_core.sv
// rtl/fcn_core.sv - gated reciprocal frequency counter core
// Optional feature macro: FCN_OVF_EN (time-counter overflow timeout with saturation)
// Ports:
//   clk     single clock
//   rst     synchronous active-high reset
//   in      asynchronous signal inputs, one per channel (2**CH_BITS)
//   chn     channel select, latched on an accepted start
//   edg     edge select (0 rising, 1 falling), latched on an accepted start
//   gate    minimum gate length in clk cycles, latched on an accepted start
//   start   measurement request, accepted only in IDLE
//   abort   cancels a measurement in ARM/RUN/HOLD
//   busy    high in ARM, RUN, HOLD
//   act     high in RUN, HOLD
//   done    one-cycle completion pulse
//   evc     counted signal periods
//   tmc     clk cycles between opening and closing edge
//   ovf     time-counter overflow flag
module fcn_core #(
   parameter int CTR_SIZE = 32,
   parameter int CH_BITS  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [(2**CH_BITS)-1:0] in,
   input  logic [CH_BITS-1:0]      chn,
   input  logic                    edg,
   input  logic [CTR_SIZE-1:0]     gate,
   input  logic                    start,
   input  logic                    abort,
   output logic                    busy,
   output logic                    act,
   output logic                    done,
   output logic [CTR_SIZE-1:0]     evc,
   output logic [CTR_SIZE-1:0]     tmc,
   output logic                    ovf
);
   localparam int CHANNELS = 2**CH_BITS;
   localparam logic [CTR_SIZE-1:0] CTR_ONE = {{(CTR_SIZE-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_HOLD,
      S_DONE
   } state_t;

   state_t state, state_nx;

   logic [CHANNELS-1:0] sync1, sync2, sync3;
   logic [CH_BITS-1:0]  chn_q;
   logic                edg_q;
   logic [CTR_SIZE-1:0] gate_q;
   logic [CTR_SIZE-1:0] gcnt;
   logic [CTR_SIZE-1:0] evc_q, tmc_q;
   logic [CTR_SIZE-1:0] evc_nx, tmc_inc;
   logic                cur, prev, hit;
   logic                ovf_hit;
   logic                latch_cfg, open_gate, count_en;

   // Every channel runs through the same three flops, so the edge latency is
   // channel independent; the mux sits after the chain.
   assign cur  = sync2[chn_q];
   assign prev = sync3[chn_q];
   assign hit  = edg_q ? (prev & ~cur) : (cur & ~prev);

   assign tmc_inc = tmc_q + CTR_ONE;

   always_comb begin
      evc_nx = evc_q;
      if (hit) begin
         evc_nx = evc_q + CTR_ONE;
      end
`ifdef FCN_OVF_EN
      if (hit && (&evc_q)) begin
         evc_nx = evc_q;
      end
`endif
   end

`ifdef FCN_OVF_EN
   // Timeout fires in the cycle the time counter lands on all-ones.
   assign ovf_hit = &tmc_inc;
`else
   assign ovf_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      latch_cfg = 1'b0;
      open_gate = 1'b0;
      count_en  = 1'b0;
      case (state)
         S_IDLE: begin
            // abort has priority over a simultaneous start
            if (start && !abort) begin
               latch_cfg = 1'b1;
               state_nx  = S_ARM;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else if (hit) begin
               open_gate = 1'b1;
               state_nx  = (gate_q == '0) ? S_HOLD : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               count_en = 1'b1;
               if (ovf_hit) begin
                  state_nx = S_DONE;
               end else if (gcnt == CTR_ONE) begin
                  // gate expires this cycle; a coincident edge closes at once
                  state_nx = hit ? S_DONE : S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (abort) begin
               state_nx = S_IDLE;
            end else begin
               count_en = 1'b1;
               if (ovf_hit || hit) begin
                  state_nx = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1  <= '0;
         sync2  <= '0;
         sync3  <= '0;
         chn_q  <= '0;
         edg_q  <= 1'b0;
         gate_q <= '0;
         gcnt   <= '0;
         evc_q  <= '0;
         tmc_q  <= '0;
      end else begin
         sync1 <= in;
         sync2 <= sync1;
         sync3 <= sync2;
         if (latch_cfg) begin
            chn_q  <= chn;
            edg_q  <= edg;
            gate_q <= gate;
         end
         if (open_gate) begin
            evc_q <= '0;
            tmc_q <= '0;
            gcnt  <= gate_q;
         end
         if (count_en) begin
            tmc_q <= tmc_inc;
            evc_q <= evc_nx;
            if (state == S_RUN) begin
               gcnt <= gcnt - CTR_ONE;
            end
         end
      end
   end

`ifdef FCN_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (latch_cfg) begin
         ovf_q <= 1'b0;
      end else if (count_en && ovf_hit) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state == S_ARM) || (state == S_RUN) || (state == S_HOLD);
   assign act  = (state == S_RUN) || (state == S_HOLD);
   assign done = (state == S_DONE);
   assign evc  = evc_q;
   assign tmc  = tmc_q;

endmodule

// File: tb/tb_fcn_core.sv
// tb/tb_fcn_core.sv - self-checking bench for fcn_core
`timescale 1ns/1ps
module tb_fcn_core;
   localparam int CTR_SIZE = 8;
   localparam int CH_BITS  = 1;
   localparam int CHANNELS = 2;
   localparam int CTR_MAX  = (1 << CTR_SIZE) - 1;
`ifdef FCN_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                rst;
   logic [CHANNELS-1:0] sig_in;
   logic [CH_BITS-1:0]  chn;
   logic                edg;
   logic [CTR_SIZE-1:0] gate;
   logic                start;
   logic                abort;
   logic                busy, act, done, ovf;
   logic [CTR_SIZE-1:0] evc, tmc;

   always #5 clk = ~clk;

   fcn_core #(.CTR_SIZE(CTR_SIZE), .CH_BITS(CH_BITS)) dut (
      .clk(clk), .rst(rst), .in(sig_in), .chn(chn), .edg(edg), .gate(gate),
      .start(start), .abort(abort), .busy(busy), .act(act), .done(done),
      .evc(evc), .tmc(tmc), .ovf(ovf)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int per [CHANNELS];
   int ph  [CHANNELS];

   // Square wave: high for the first per/2 cycles of each period; per 0 = idle low.
   function automatic logic wave(int ch, int n);
      if (per[ch] == 0 || n < 0) return 1'b0;
      return ((n + per[ch] - ph[ch]) % per[ch]) < (per[ch] / 2);
   endfunction

   function automatic logic qual(int ch, logic e, int n);
      logic v, pv;
      v  = wave(ch, n);
      pv = wave(ch, n - 1);
      return e ? (pv & ~v) : (v & ~pv);
   endfunction

   // Reference: first qualifying edge driven at or after cycle s-1 opens; the
   // first later edge at least max(gate,1) cycles on closes.
   function automatic void model(input int ch, input logic e, input int g, input int s,
                                 output int m_evc, output int m_tmc, output logic m_ovf);
      int e0, k, span;
      e0 = -1; k = 0; span = (g == 0) ? 1 : g;
      m_evc = -1; m_tmc = -1; m_ovf = 1'b0;
      for (int n = s - 1; n < s + 3000; n++) begin
         if (qual(ch, e, n)) begin e0 = n; break; end
      end
      if (e0 < 0) return;
      for (int n = e0 + 1; n < e0 + 3000; n++) begin
         if (qual(ch, e, n)) k++;
         if (OVF_EN && (n - e0) >= CTR_MAX) begin
            m_ovf = 1'b1; m_tmc = CTR_MAX; m_evc = (k > CTR_MAX) ? CTR_MAX : k;
            return;
         end
         if (qual(ch, e, n) && (n - e0) >= span) begin
            m_tmc = (n - e0) % (CTR_MAX + 1); m_evc = k % (CTR_MAX + 1);
            return;
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < CHANNELS; c++) sig_in[c] = wave(c, cyc);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic settle(input int p0, input int h0, input int p1, input int h1);
      per[0] = p0; ph[0] = h0; per[1] = p1; ph[1] = h1;
      repeat (40) tick();
   endtask

   task automatic measure(input string name, input int ch, input logic e, input int g,
                          input bit poke, input int x_evc, input int x_tmc, input logic x_ovf);
      bit seen, poked;
      chn = ch[CH_BITS-1:0]; edg = e; gate = CTR_SIZE'(g); start = 1'b1;
      tick();
      start = 1'b0;
      check({name, ".busy_arm"}, busy, 1);
      seen = 1'b0; poked = 1'b0;
      for (int b = 0; b < 3000 && !seen; b++) begin
         if (poke && act && !poked) begin
            start = 1'b1; chn = ~chn; gate = '0; poked = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({name, ".done_seen"}, seen, 1);
      if (poke) check({name, ".poke_applied"}, poked, 1);
      check({name, ".evc"}, evc, x_evc);
      check({name, ".tmc"}, tmc, x_tmc);
      check({name, ".ovf"}, ovf, x_ovf);
      tick();
      check({name, ".done_pulse"}, done, 0);
      check({name, ".busy_after"}, busy, 0);
   endtask

   task automatic wait_act(input string name);
      bit seen;
      seen = 1'b0;
      for (int b = 0; b < 2000 && !seen; b++) begin
         tick();
         if (act) seen = 1'b1;
      end
      check({name, ".act_seen"}, seen, 1);
   endtask

   typedef struct {
      int   ch;
      logic e;
      int   g;
      int   p0, h0, p1, h1;
      int   x_evc, x_tmc;
      logic x_ovf;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int   s, m_evc, m_tmc, rch, rg;
      logic m_ovf, re;
      bit   dseen;

      vecs[0] = '{0, 1'b0, 100, 10, 3, 0, 0, 10, 100, 1'b0};
      vecs[1] = '{1, 1'b1, 0, 3, 1, 7, 2, 1, 7, 1'b0};
      vecs[2] = '{0, 1'b0, 95, 10, 4, 0, 0, 10, 100, 1'b0};
      vecs[3] = OVF_EN ? '{0, 1'b0, 0, 300, 5, 0, 0, 0, 255, 1'b1}
                       : '{0, 1'b0, 0, 300, 5, 0, 0, 1, 44, 1'b0};
      vecs[4] = '{0, 1'b1, 20, 6, 2, 0, 0, 4, 24, 1'b0};
      vecs[5] = '{1, 1'b0, 1, 4, 1, 5, 3, 1, 5, 1'b0};

      per[0] = 0; ph[0] = 0; per[1] = 0; ph[1] = 0;
      sig_in = '0; chn = '0; edg = 1'b0; gate = '0; start = 1'b0; abort = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      check("reset.busy", busy, 0);
      check("reset.act", act, 0);
      check("reset.done", done, 0);
      check("reset.evc", evc, 0);
      check("reset.tmc", tmc, 0);
      check("reset.ovf", ovf, 0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         settle(vecs[i].p0, vecs[i].h0, vecs[i].p1, vecs[i].h1);
         measure($sformatf("vec%0d", i), vecs[i].ch, vecs[i].e, vecs[i].g, 1'b0,
                 vecs[i].x_evc, vecs[i].x_tmc, vecs[i].x_ovf);
      end

      for (int i = 0; i < 16; i++) begin
         int p0, p1;
         p0 = $urandom_range(25, 4); p1 = $urandom_range(25, 4);
         settle(p0, $urandom_range(p0 - 1, 0), p1, $urandom_range(p1 - 1, 0));
         rch = $urandom_range(1, 0); re = 1'($urandom_range(1, 0)); rg = $urandom_range(60, 0);
         s = cyc;
         model(rch, re, rg, s, m_evc, m_tmc, m_ovf);
         measure($sformatf("rnd%0d", i), rch, re, rg, 1'b0, m_evc, m_tmc, m_ovf);
      end

      // start while busy is ignored
      settle(10, 0, 3, 1);
      measure("busy_start", 0, 1'b0, 100, 1'b1, 10, 100, 1'b0);

      // abort in RUN: tmc counts 12 cycles past the opening edge, one edge seen
      settle(10, 0, 0, 0);
      chn = '0; edg = 1'b0; gate = 8'd100; start = 1'b1;
      tick();
      start = 1'b0;
      wait_act("abort_run");
      repeat (12) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_run.busy", busy, 0);
      check("abort_run.act", act, 0);
      dseen = 1'b0;
      for (int b = 0; b < 20; b++) begin
         tick();
         if (done) dseen = 1'b1;
      end
      check("abort_run.no_done", dseen, 0);
      check("abort_run.tmc_hold", tmc, 12);
      check("abort_run.evc_hold", evc, 1);

      // start together with abort in IDLE
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      check("start_abort.busy", busy, 0);
      tick();
      check("start_abort.busy2", busy, 0);

      // reset while in HOLD, then a normal measurement
      settle(50, 0, 0, 0);
      chn = '0; edg = 1'b0; gate = '0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_act("rst_hold");
      repeat (5) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_hold.busy", busy, 0);
      check("rst_hold.act", act, 0);
      check("rst_hold.done", done, 0);
      check("rst_hold.evc", evc, 0);
      check("rst_hold.tmc", tmc, 0);
      check("rst_hold.ovf", ovf, 0);
      settle(10, 7, 0, 0);
      measure("after_rst", 0, 1'b0, 100, 1'b0, 10, 100, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fcn_core.md
FCN_CORE -- requirements
Module: fcn_core

Interface
REQ-001 Parameter CTR_SIZE, default 32: width of event counter, time counter and gate register.
REQ-002 Parameter CH_BITS, default 1: channel-select width; channel count CHANNELS = 2**CH_BITS.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in  input  CHANNELS  asynchronous signal inputs, one per channel.
REQ-006 chn  input  CH_BITS  channel select, sampled on an accepted start.
REQ-007 edg  input  1  edge select, sampled on an accepted start; 0 = rising, 1 = falling.
REQ-008 gate  input  CTR_SIZE  minimum gate length in clk cycles, sampled on an accepted start.
REQ-009 start  input  1  measurement request; accepted only in IDLE.
REQ-010 abort  input  1  cancels any measurement in progress.
REQ-011 busy  output  1  high in ARM, RUN and HOLD.
REQ-012 act  output  1  high in RUN and HOLD (gate open).
REQ-013 done  output  1  one-cycle pulse on completion.
REQ-014 evc  output  CTR_SIZE  counted signal periods.
REQ-015 tmc  output  CTR_SIZE  clk cycles between the opening edge and the closing edge.
REQ-016 ovf  output  1  time-counter overflow flag.

Function
REQ-017 Each in bit SHALL pass a 2-flop synchronizer plus one delay flop; a qualifying edge is a 0->1 transition (edg=0) or a 1->0 transition (edg=1) on the selected channel; latency is identical on all channels.
REQ-018 The FSM SHALL have the states IDLE, ARM, RUN, HOLD and DONE.
REQ-019 IDLE + start: latch chn/edg/gate, clear ovf, go to ARM; evc/tmc hold their previous results until the opening edge.
REQ-020 ARM + edge: clear evc and tmc to 0, load the gate down-counter with gate, go to RUN (or to HOLD if gate == 0).
REQ-021 RUN/HOLD: tmc increments every cycle, including the closing-edge cycle; evc increments on every qualifying edge.
REQ-022 RUN: the down-counter decrements every cycle; at 1->0 with no edge go to HOLD; at 1->0 with an edge in the same cycle, count that edge and go to DONE.
REQ-023 HOLD + edge: count the edge and go to DONE.
REQ-024 DONE: assert done for exactly one cycle, go to IDLE; evc/tmc/ovf stay stable until the next opening edge.
REQ-025 start while busy or in DONE SHALL be ignored.
REQ-026 abort in ARM/RUN/HOLD: go to IDLE next cycle with no done pulse; evc/tmc keep their current values.
REQ-027 start and abort asserted together in IDLE: abort wins and start is not accepted.
REQ-028 abort in IDLE or DONE SHALL have no effect.
REQ-029 Result definition: frequency = evc * F_clk / tmc.

Reset
REQ-030 When rst is high at a clk edge, the block SHALL enter IDLE on that edge, including mid-measurement.
REQ-031 Reset values: busy=0, act=0, done=0, evc=0, tmc=0, ovf=0, gate down-counter=0, synchronizer flops=0.

Configuration
REQ-032 Macro FCN_OVF_EN defined: when tmc reaches all-ones in RUN/HOLD, set ovf=1, saturate tmc and evc, and go to DONE with a done pulse (no-signal timeout).
REQ-033 Macro FCN_OVF_EN undefined: tmc and evc wrap modulo 2**CTR_SIZE, ovf is tied to 0, and there is no timeout.

Verification
REQ-034 Scenario: ch0 square wave, period 10 clk; edg=0, gate=100 -> done pulse, evc=10, tmc=100, ovf=0.
REQ-035 Scenario: ch1 (CH_BITS=1) period 7 clk, edg=1, gate=0 -> evc=1, tmc=7; ch0 activity has no effect.
REQ-036 Scenario: period 10 clk, gate=95 -> gate closes with no edge, state is HOLD, next edge closes -> evc=10, tmc=100.
REQ-037 Scenario: CTR_SIZE=8, period 300 clk, gate=0 -> with FCN_OVF_EN: tmc=255, ovf=1, done; without FCN_OVF_EN: tmc=44, ovf=0.
REQ-038 Scenario: abort in RUN -> busy low next cycle, no done pulse; start+abort in IDLE -> stays in IDLE.
REQ-039 Scenario: rst in HOLD -> next cycle all outputs at reset values; a subsequent start measures normally.
